corescore_uart_bridge: RTL and testbench

Byte-stream bridge between the corescore core's AXI-Stream byte output and the JTAG-UART write port. It buffers bytes in a small synchronous FIFO so the core is not stalled by every UART back-pressure cycle. It also enforces the UART rule that a byte may only be presented one cycle after the UART signals ready. It sits directly downstream of `corescorecore` and directly upstream of `alt_jtag_atlantic`, and replaces the ad-hoc tready/r_dat pipeline register in the top level.

---
 rtl/corescore_uart_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_corescore_uart_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corescore_uart_bridge.sv
// corescore_uart_bridge
//
// Byte-stream bridge from the corescore core's AXI-Stream byte output to the
// JTAG-UART write port. Bytes are buffered in a small synchronous FIFO so the
// core is not stalled on every UART back-pressure cycle. A byte is only
// presented to the UART one cycle after the UART signals ready.
//
// Optional feature macro: CORESCORE_UART_BRIDGE_CRLF_EN
//   When defined, every 8'h0A is preceded by an inserted 8'h0D on the UART side.
//   When undefined, bytes pass through unchanged and no LF_PEND logic is built.
//
// Parameters
//   DEPTH_LOG2 : FIFO depth is 2^DEPTH_LOG2 entries (1..8)
//   CNT_W      : width of the frame-end counter
//
// Ports
//   i_clk      : clock, rising edge
//   i_rst_n    : synchronous active-low reset
//   i_tdata    : stream byte from the core
//   i_tlast    : last byte of a frame
//   i_tvalid   : stream valid
//   o_tready   : stream ready (FIFO not full, forced low during reset)
//   o_dat      : byte to the UART
//   o_val      : byte strobe to the UART
//   i_ena      : UART can accept a byte
//   o_last     : strobed byte is a frame end
//   o_level    : FIFO occupancy
//   o_frames   : number of frame-end bytes delivered (wraps)

module corescore_uart_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_tdata,
  input  logic                  i_tlast,
  input  logic                  i_tvalid,
  output logic                  o_tready,
  output logic [7:0]            o_dat,
  output logic                  o_val,
  input  logic                  i_ena,
  output logic                  o_last,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic [CNT_W-1:0]      o_frames
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2+1)'(32'd0);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(32'd1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(32'd0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(32'd1);
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(32'd1);

  typedef enum logic [0:0] {
    S_PASS    = 1'b0,
    S_LF_PEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [8:0]              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic [7:0]              dat_q, dat_d;
  logic                    val_q, val_d;
  logic                    last_q, last_d;
  logic [CNT_W-1:0]        frames_q, frames_d;

  logic                    push_s;
  logic                    pop_s;
  logic                    elig_s;
  logic [8:0]              head_s;

  // Ready comes only from the registered level, so a same-cycle pop never
  // reopens a full FIFO; reset forces it low.
  assign o_tready = i_rst_n & (level_q != FULL_LVL);
  assign push_s   = i_tvalid & o_tready;
  assign elig_s   = i_ena & (level_q != LVL_ZERO);
  assign head_s   = mem_q[rptr_q];

  assign o_dat    = dat_q;
  assign o_val    = val_q;
  assign o_last   = last_q;
  assign o_level  = level_q;
  assign o_frames = frames_q;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
`ifdef CORESCORE_UART_BRIDGE_CRLF_EN
    case (state_q)
      S_PASS: begin
        if (elig_s && (head_s[7:0] == 8'h0A)) begin
          state_d = S_LF_PEND;
        end else begin
          state_d = S_PASS;
        end
      end
      S_LF_PEND: begin
        if (elig_s) begin
          state_d = S_PASS;
        end else begin
          state_d = S_LF_PEND;
        end
      end
      default: state_d = S_PASS;
    endcase
`else
    state_d = S_PASS;
`endif
  end

  // FSM output logic: decides pop and the next UART byte/strobe
  always_comb begin
    pop_s  = 1'b0;
    val_d  = 1'b0;
    last_d = 1'b0;
    dat_d  = dat_q;
    case (state_q)
      S_PASS: begin
        if (elig_s) begin
`ifdef CORESCORE_UART_BRIDGE_CRLF_EN
          if (head_s[7:0] == 8'h0A) begin
            // Insert CR ahead of the LF; the LF stays at the head.
            pop_s  = 1'b0;
            val_d  = 1'b1;
            dat_d  = 8'h0D;
            last_d = 1'b0;
          end else begin
            pop_s  = 1'b1;
            val_d  = 1'b1;
            dat_d  = head_s[7:0];
            last_d = head_s[8];
          end
`else
          pop_s  = 1'b1;
          val_d  = 1'b1;
          dat_d  = head_s[7:0];
          last_d = head_s[8];
`endif
        end else begin
          pop_s  = 1'b0;
          val_d  = 1'b0;
          dat_d  = dat_q;
          last_d = 1'b0;
        end
      end
`ifdef CORESCORE_UART_BRIDGE_CRLF_EN
      S_LF_PEND: begin
        if (elig_s) begin
          pop_s  = 1'b1;
          val_d  = 1'b1;
          dat_d  = 8'h0A;
          last_d = head_s[8];
        end else begin
          pop_s  = 1'b0;
          val_d  = 1'b0;
          dat_d  = dat_q;
          last_d = 1'b0;
        end
      end
`endif
      default: begin
        pop_s  = 1'b0;
        val_d  = 1'b0;
        dat_d  = dat_q;
        last_d = 1'b0;
      end
    endcase
  end

  // FIFO pointer/level and frame counter next-state
  always_comb begin
    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (val_d && last_d) begin
      frames_d = frames_q + CNT_ONE;
    end else begin
      frames_d = frames_q;
    end
  end

  // FIFO storage; no reset needed since pointers/level gate what is valid
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= {i_tlast, i_tdata};
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q   <= PTR_ZERO;
      rptr_q   <= PTR_ZERO;
      level_q  <= LVL_ZERO;
      dat_q    <= 8'h00;
      val_q    <= 1'b0;
      last_q   <= 1'b0;
      frames_q <= CNT_ZERO;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      dat_q    <= dat_d;
      val_q    <= val_d;
      last_q   <= last_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_corescore_uart_bridge.sv
// Self-checking bench for corescore_uart_bridge. A main instance uses the
// default parameters; a second instance with CNT_W = 4 covers counter wrap.
module tb_corescore_uart_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  tdata;
  logic        tlast, tvalid, ena;
  logic        tready, val, last;
  logic [7:0]  dat;
  logic [4:0]  level;
  logic [15:0] frames;

  logic [7:0]  w_tdata;
  logic        w_tlast, w_tvalid, w_ena;
  logic        w_tready, w_val, w_last;
  logic [7:0]  w_dat;
  logic [4:0]  w_level;
  logic [3:0]  w_frames;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bad_strobe = 0;
  logic mon_ena;
  logic [8:0] rx_q[$];
  int         rx_cyc[$];
  logic [8:0] tx[$];
  logic [8:0] exp_q[$];

  corescore_uart_bridge #(.DEPTH_LOG2(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid), .o_tready(tready), .o_dat(dat), .o_val(val),
    .i_ena(ena), .o_last(last), .o_level(level), .o_frames(frames)
  );

  corescore_uart_bridge #(.DEPTH_LOG2(4), .CNT_W(4)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(w_tdata), .i_tlast(w_tlast),
    .i_tvalid(w_tvalid), .o_tready(w_tready), .o_dat(w_dat), .o_val(w_val),
    .i_ena(w_ena), .o_last(w_last), .o_level(w_level), .o_frames(w_frames)
  );

  // Output monitor: logs every strobe and flags any strobe not preceded by ena
  always begin
    @(posedge clk);
    mon_ena = ena;
    #1;
    cyc++;
    if (val === 1'b1) begin
      rx_q.push_back({last, dat});
      rx_cyc.push_back(cyc);
      if (mon_ena !== 1'b1) bad_strobe++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic send();
    int i = 0;
    int guard = 0;
    while (i < tx.size() && guard < 1000) begin
      @(negedge clk);
      tdata  = tx[i][7:0];
      tlast  = tx[i][8];
      tvalid = 1'b1;
      if (tready === 1'b1) i++;
      guard++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    tests++;
    if (i != tx.size()) begin
      fails++;
      $display("FAIL send_timeout: sent %0d bytes, required %0d", i, tx.size());
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (level !== 5'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    tests++;
    if (level !== 5'd0) begin
      fails++;
      $display("FAIL drain_timeout: level %0d, required 0", level);
    end
  endtask

  task automatic check_rx(input string name);
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        tests++;
        if (rx_q[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL %s_byte[%0d]: got %h, required %h", name, k, rx_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tvalid = 1'b0; tdata = 8'h00; tlast = 1'b0; ena = 1'b0;
    w_tvalid = 1'b0; w_tdata = 8'h00; w_tlast = 1'b0; w_ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (tready !== 1'b0 || val !== 1'b0 || frames !== 16'd0) begin
        fails++;
        $display("FAIL reset_hold: tready=%b val=%b frames=%0d, required 0/0/0", tready, val, frames);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (tready !== 1'b1 || level !== 5'd0) begin
      fails++;
      $display("FAIL reset_release: tready=%b level=%0d, required 1/0", tready, level);
    end
  endtask

  task automatic test_stream();
    logic [7:0] msg [7];
    msg = '{8'h43, 8'h6F, 8'h72, 8'h65, 8'h20, 8'h30, 8'h0A};
    rx_q.delete(); rx_cyc.delete(); tx.delete(); exp_q.delete();
    ena = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tx.push_back({(msg[k] == 8'h0A), msg[k]});
`ifdef CORESCORE_UART_BRIDGE_CRLF_EN
      if (msg[k] == 8'h0A) exp_q.push_back({1'b0, 8'h0D});
`endif
      exp_q.push_back({(msg[k] == 8'h0A), msg[k]});
    end
    send();
    wait_drain();
    check_rx("stream");
    for (int k = 1; k < rx_cyc.size(); k++) begin
      tests++;
      if (rx_cyc[k] != rx_cyc[0] + k) begin
        fails++;
        $display("FAIL stream_b2b[%0d]: strobe cycle %0d, required %0d", k, rx_cyc[k], rx_cyc[0] + k);
      end
    end
    tests++;
    if (frames !== 16'd1) begin
      fails++;
      $display("FAIL stream_frames: got %0d, required 1", frames);
    end
  endtask

  task automatic test_full();
    int i = 0;
    int guard = 0;
    rx_q.delete(); exp_q.delete();
    ena = 1'b0;
    for (int k = 0; k < 20; k++) exp_q.push_back({1'b0, 8'(8'h10 + k)});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tdata = exp_q[i][7:0]; tlast = 1'b0; tvalid = 1'b1;
      if (tready === 1'b1) i++;
    end
    tests++;
    if (i != 16 || level !== 5'd16 || tready !== 1'b0) begin
      fails++;
      $display("FAIL full_state: accepted=%0d level=%0d tready=%b, required 16/16/0", i, level, tready);
    end
    ena = 1'b1;
    @(negedge clk);
    tests++;
    if (tready !== 1'b1 || level !== 5'd15) begin
      fails++;
      $display("FAIL full_reopen: tready=%b level=%0d, required 1/15", tready, level);
    end
    if (tready === 1'b1) i++;
    while (i < 20 && guard < 200) begin
      @(negedge clk);
      tdata = exp_q[i][7:0];
      if (tready === 1'b1) i++;
      guard++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    wait_drain();
    check_rx("full");
  endtask

  task automatic test_ena_toggle();
    int bad0;
    tx.delete(); exp_q.delete();
    ena = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tx.push_back({1'b0, 8'(8'h30 + k)});
      exp_q.push_back({1'b0, 8'(8'h30 + k)});
    end
    send();
    tests++;
    if (level !== 5'd8) begin
      fails++;
      $display("FAIL toggle_level: got %0d, required 8", level);
    end
    rx_q.delete();
    bad0 = bad_strobe;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ena = (c % 2 == 0);
    end
    @(negedge clk);
    ena = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (bad_strobe != bad0) begin
      fails++;
      $display("FAIL toggle_strobe: %0d strobes without ena, required 0", bad_strobe - bad0);
    end
    check_rx("toggle");
  endtask

  task automatic test_reset_mid();
    tx.delete(); exp_q.delete();
    ena = 1'b0;
    tx.push_back({1'b0, 8'h0A});
    for (int k = 1; k < 5; k++) tx.push_back({1'b0, 8'(8'h50 + k)});
    send();
    // One eligible cycle: with CRLF this leaves the FSM in LF_PEND.
    @(negedge clk); ena = 1'b1;
    @(negedge clk); ena = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (level !== 5'd0 || tready !== 1'b1 || val !== 1'b0 || frames !== 16'd0) begin
      fails++;
      $display("FAIL midrst_state: level=%0d tready=%b val=%b frames=%0d, required 0/1/0/0",
               level, tready, val, frames);
    end
    rx_q.delete();
    ena = 1'b1;
    repeat (6) @(negedge clk);
    tests++;
    if (rx_q.size() != 0) begin
      fails++;
      $display("FAIL midrst_quiet: got %0d strobes, required 0", rx_q.size());
    end
    tx.delete();
    tx.push_back({1'b0, 8'h41});
    exp_q.push_back({1'b0, 8'h41});
    send();
    wait_drain();
    check_rx("midrst");
  endtask

  task automatic test_frame_wrap();
    int acc = 0;
    w_ena = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      w_tdata = 8'h41; w_tlast = 1'b1; w_tvalid = 1'b1;
      if (w_tready === 1'b1) acc++;
    end
    @(negedge clk); w_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (w_frames !== 4'd15 || acc != 15) begin
      fails++;
      $display("FAIL wrap_15: frames=%0d accepted=%0d, required 15/15", w_frames, acc);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      w_tdata = 8'h42; w_tlast = 1'b1; w_tvalid = 1'b1;
      if (w_tready === 1'b1) acc++;
    end
    @(negedge clk); w_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (w_frames !== 4'd1 || acc != 17) begin
      fails++;
      $display("FAIL wrap_17: frames=%0d accepted=%0d, required 1/17", w_frames, acc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_ena_toggle();
    test_reset_mid();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
